cd_spi_csr: RTL and testbench
=============================

CD_SPI_CSR -- requirements
Module: cd_spi_csr

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on spi_sck, spi_ss_n and spi_mosi (minimum 2).
REQ-002 SHALL have one clock and an asynchronous active-high reset.
REQ-003 Ports: clk  in  1  system clock.
REQ-004 Ports: reset  in  1  asynchronous, active-high.
REQ-005 Ports: spi_sck  in  1  SPI clock, mode 0, async to clk.
REQ-006 Ports: spi_ss_n  in  1  chip select, active-low.
REQ-007 Ports: spi_mosi  in  1  host-to-device data, MSB first.
REQ-008 Ports: spi_miso  out  1  device-to-host data.
REQ-009 Ports: spi_miso_oe  out  1  MISO drive enable (1 while ss_n low).
REQ-010 Ports: csr_address  out  5  CSR address to the cdbus core.
REQ-011 Ports: csr_read  out  1  one-cycle read strobe.
REQ-012 Ports: csr_readdata  in  8  read data, valid exactly 1 clk after csr_read.
REQ-013 Ports: csr_write  out  1  one-cycle write strobe.
REQ-014 Ports: csr_writedata  out  8  write data, valid with csr_write.

Function
REQ-015 SHALL use the last synchronizer stage only; SCK edges SHALL be detected by comparing the current and previous synchronized values; supported f_sck <= f_clk/8.
REQ-016 On each SCK rising edge, SHALL shift synchronized MOSI into the rx shift register and increment a 3-bit bit counter; a byte completes when the counter wraps 7->0.
REQ-017 On each SCK falling edge, SHALL shift the tx register left and drive its MSB on spi_miso.
REQ-018 FSM states: IDLE, CMD, WR, RD.
  - IDLE->CMD when ss_n falls; bit counter cleared.
  - Any state->IDLE when ss_n is high; a partial byte is discarded with no CSR access.
REQ-019 Command byte: bit7 = 1 write / 0 read; bit6 = auto-increment; bit5 = ignored; bits4:0 = start address.
REQ-020 On CMD byte completion:
  - latch the address and inc flag;
  - go to WR if bit7 = 1;
  - go to RD if bit7 = 0, asserting csr_read on the next clk.
REQ-021 WR: each completed byte SHALL produce csr_write for one clk, 1 clk after the completing rising edge, with csr_writedata = the byte and csr_address = the current address; the address SHALL then increment if inc = 1.
REQ-022 RD:
  - csr_readdata SHALL be captured 1 clk after csr_read and loaded into the tx register, so its MSB is driven on spi_miso before the next SCK falling edge (guaranteed by REQ-015);
  - on each completed byte, the address SHALL increment if inc = 1 and csr_read SHALL be issued again.
REQ-023 Read prefetch: the final csr_read in a burst is issued even though the host does not clock that byte out; this is the defined behaviour, and the host accounts for it on FIFO-type registers.
REQ-024 Address arithmetic SHALL be 5-bit with wrap 31->0.
REQ-025 spi_miso SHALL be 0 during CMD and WR; spi_miso_oe = ~ss_n (synchronized).
REQ-026 csr_read and csr_write SHALL never be asserted in the same clk; each is at most one pulse per byte.
REQ-027 If ss_n rises in the same clk as a byte completion, the byte SHALL be completed (write issued) before returning to IDLE.

Reset
REQ-028 On reset:
  - state = IDLE; shift registers, bit counter and address = 0;
  - csr_read = csr_write = 0; csr_writedata = 0;
  - spi_miso = 0; spi_miso_oe = 0; synchronizers preset to sck = 0, ss_n = 1, mosi = 0.
REQ-029 Reset mid-transaction SHALL abandon it; no CSR strobe is issued in or after the reset cycle until a new ss_n fall.

Structure
REQ-030 A shared package SHALL hold the FSM state encodings, the command bit positions (CMD_WR = 7, CMD_INC = 6) and the address width (5).
REQ-031 One sub-module, cd_sync, SHALL implement the parameterized N-stage synchronizer (instanced three times).

Verification
REQ-032 Write burst:
  - stimulus: ss_n low, bytes 0xC3, 0x11, 0x22, 0x33, ss_n high;
  - response: csr_write at addresses 3, 4, 5 with data 0x11, 0x22, 0x33.
REQ-033 Read, no increment:
  - stimulus: 0x02 then 2 dummy bytes, with csr_readdata model returning 0xA5, 0x5A;
  - response: MISO bytes 0x00, 0xA5, 0x5A; three csr_read pulses, all at address 2.
REQ-034 Address wrap:
  - stimulus: 0xDF, 0x01, 0x02;
  - response: writes to address 31 then address 0.
REQ-035 Abort:
  - stimulus: 0x85, then 4 bits of a data byte, then ss_n high;
  - response: no csr_write; the next transaction 0x86, 0x77 writes 0x77 to address 6.
REQ-036 Reset mid-byte:
  - stimulus: reset pulse during a WR data byte;
  - response: all outputs reach their reset values asynchronously, and no strobe is issued afterwards.
REQ-037 Max rate:
  - stimulus: f_sck = f_clk/8 with random read/write bursts of 1-16 bytes;
  - response: a scoreboard matches all CSR traffic and all MISO bytes.

Source files
------------

// File: rtl/cd_spi_csr_pkg.sv
// Shared types and constants for the SPI-to-CSR bridge.
// FSM encoding, command byte layout and address width.
package cd_spi_csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_e;

  localparam int CMD_WR  = 7;
  localparam int CMD_INC = 6;
  localparam int AW      = 5;

endpackage

// File: rtl/cd_spi_csr_sync.sv
// N-stage flop synchronizer with a selectable reset value.
// Used for SCK, SS_N and MOSI crossing into the clk domain.
module cd_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {N{RST_VAL}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/cd_spi_csr.sv
// SPI mode-0 slave bridging command/data bytes onto a small CSR bus.
// Command byte: wr, auto-inc, unused, 5-bit start address.
module cd_spi_csr
  import cd_spi_csr_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          spi_sck,
  input  logic          spi_ss_n,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  output logic [AW-1:0] csr_address,
  output logic          csr_read,
  input  logic [7:0]    csr_readdata,
  output logic          csr_write,
  output logic [7:0]    csr_writedata
);

  localparam int SW = $clog2(SYNC_STAGES + 1);

  logic sck_s, ss_s, mosi_s;

  cd_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d_i(spi_sck), .q_o(sck_s)
  );
  cd_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d_i(spi_ss_n), .q_o(ss_s)
  );
  cd_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(spi_mosi), .q_o(mosi_s)
  );

  state_e        state_q, state_d;
  logic          sck_prev_q;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [6:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic          miso_q, miso_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          inc_q, inc_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rdpend_q;
  logic [SW-1:0] settle_q, settle_d;
  logic          armed_q, armed_d;

  logic          rise, fall, byte_done;
  logic [7:0]    byte_w;
  logic [AW-1:0] addr_step;

  assign rise      = sck_s & ~sck_prev_q;
  assign fall      = ~sck_s & sck_prev_q;
  assign byte_w    = {rx_q, mosi_s};
  assign byte_done = rise && (bitcnt_q == 3'd7) && (state_q != ST_IDLE);
  assign addr_step = addr_q + {{(AW-1){1'b0}}, inc_q};

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    miso_d   = miso_q;
    addr_d   = addr_q;
    inc_d    = inc_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    wdata_d  = wdata_q;
    settle_d = settle_q;
    armed_d  = armed_q;

    // After reset the synchronizers show a fake SS_N fall; wait for a real high.
    if (!armed_q) begin
      if (settle_q != SW'(SYNC_STAGES)) begin
        settle_d = settle_q + SW'(1);
      end else if (ss_s) begin
        armed_d = 1'b1;
      end
    end

    if (wr_q) begin
      addr_d = addr_step;
    end

    if (state_q == ST_IDLE) begin
      bitcnt_d = 3'd0;
      rx_d     = 7'd0;
      tx_d     = 8'd0;
      miso_d   = 1'b0;
      if (armed_q && !ss_s) begin
        state_d = ST_CMD;
      end
    end else begin
      if (rise) begin
        rx_d     = byte_w[6:0];
        bitcnt_d = bitcnt_q + 3'd1;
      end
      if (fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (rdpend_q) begin
        tx_d   = csr_readdata;
        miso_d = csr_readdata[7];
      end
      if (byte_done) begin
        unique case (state_q)
          ST_CMD: begin
            addr_d = byte_w[AW-1:0];
            inc_d  = byte_w[CMD_INC];
            if (byte_w[CMD_WR]) begin
              state_d = ST_WR;
            end else begin
              state_d = ST_RD;
              rd_d    = 1'b1;
            end
          end
          ST_WR: begin
            wr_d    = 1'b1;
            wdata_d = byte_w;
          end
          ST_RD: begin
            addr_d = addr_step;
            rd_d   = 1'b1;
          end
          default: ;
        endcase
      end
      if (ss_s) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sck_prev_q <= 1'b0;
      bitcnt_q   <= 3'd0;
      rx_q       <= 7'd0;
      tx_q       <= 8'd0;
      miso_q     <= 1'b0;
      addr_q     <= '0;
      inc_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 8'd0;
      rdpend_q   <= 1'b0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_prev_q <= sck_s;
      bitcnt_q   <= bitcnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      addr_q     <= addr_d;
      inc_q      <= inc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      rdpend_q   <= rd_q;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
    end
  end

  assign spi_miso      = miso_q;
  assign spi_miso_oe   = ~ss_s;
  assign csr_address   = addr_q;
  assign csr_read      = rd_q;
  assign csr_write     = wr_q;
  assign csr_writedata = wdata_q;

endmodule

// File: tb/tb_cd_spi_csr.sv
// Directed + random bench for cd_spi_csr with a CSR/MISO scoreboard.
// SCK runs at f_clk/8, driven on clk falling edges.
module tb_cd_spi_csr;

  typedef struct packed {
    logic       wr;
    logic [4:0] a;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_ss_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata = 8'h00;
  logic       csr_write;
  logic [7:0] csr_writedata;

  int ncmp = 0;
  int nerr = 0;

  ev_t        exp_q[$];
  logic [7:0] rdq[$];
  logic [7:0] mq[$];

  always #5 clk = ~clk;

  cd_spi_csr #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_sck      (spi_sck),
    .spi_ss_n     (spi_ss_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .csr_address  (csr_address),
    .csr_read     (csr_read),
    .csr_readdata (csr_readdata),
    .csr_write    (csr_write),
    .csr_writedata(csr_writedata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    ncmp++;
    nerr++;
    $error("FAIL %s: observed event expected none", tag);
  endtask

  always @(posedge clk) begin
    if (csr_read) csr_readdata <= (rdq.size() != 0) ? rdq.pop_front() : 8'h00;
  end

  always @(negedge clk) begin
    ev_t e;
    if (!reset && (csr_read || csr_write)) begin
      chk("rd_wr_excl", {31'd0, csr_read & csr_write}, 32'd0);
      if (exp_q.size() == 0) begin
        fail_now("unexpected_strobe");
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", {31'd0, csr_write}, {31'd0, e.wr});
        chk("csr_addr", {27'd0, csr_address}, {27'd0, e.a});
        if (e.wr) chk("csr_wdata", {24'd0, csr_writedata}, {24'd0, e.d});
      end
    end
  end

  task automatic exp_w(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back('{wr: 1'b1, a: a, d: d});
  endtask

  task automatic exp_r(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back('{wr: 1'b0, a: a, d: 8'h00});
    rdq.push_back(d);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nb);
    logic [7:0] rx;
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      spi_mosi = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    if (nb == 8) begin
      if (mq.size() == 0) fail_now("miso_underflow");
      else chk("miso_byte", {24'd0, rx}, {24'd0, mq.pop_front()});
    end
  endtask

  task automatic tx_byte(input logic [7:0] tx, input logic [7:0] mexp);
    mq.push_back(mexp);
    xfer(tx, 8);
  endtask

  task automatic txn_begin();
    spi_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("miso_oe_on", {31'd0, spi_miso_oe}, 32'd1);
  endtask

  task automatic txn_end();
    repeat (4) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("miso_oe_off", {31'd0, spi_miso_oe}, 32'd0);
    chk("miso_idle", {31'd0, spi_miso}, 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd"}, {31'd0, csr_read}, 32'd0);
    chk({tag, "_wr"}, {31'd0, csr_write}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, csr_writedata}, 32'd0);
    chk({tag, "_addr"}, {27'd0, csr_address}, 32'd0);
    chk({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
    chk({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd0);
  endtask

  initial begin
    logic       wr, inc, b5;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] dv[$];
    int         n;

    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // write burst, auto-increment from 3
    exp_w(5'd3, 8'h11);
    exp_w(5'd4, 8'h22);
    exp_w(5'd5, 8'h33);
    txn_begin();
    tx_byte(8'hC3, 8'h00);
    tx_byte(8'h11, 8'h00);
    tx_byte(8'h22, 8'h00);
    tx_byte(8'h33, 8'h00);
    txn_end();

    // read, no increment; third read is the prefetch
    exp_r(5'd2, 8'hA5);
    exp_r(5'd2, 8'h5A);
    exp_r(5'd2, 8'h3C);
    txn_begin();
    tx_byte(8'h02, 8'h00);
    tx_byte(8'hFF, 8'hA5);
    tx_byte(8'h00, 8'h5A);
    txn_end();

    // address wrap 31 -> 0
    exp_w(5'd31, 8'h01);
    exp_w(5'd0, 8'h02);
    txn_begin();
    tx_byte(8'hDF, 8'h00);
    tx_byte(8'h01, 8'h00);
    tx_byte(8'h02, 8'h00);
    txn_end();

    // abort after 4 data bits, then a clean write
    txn_begin();
    tx_byte(8'h85, 8'h00);
    xfer(8'hE7, 4);
    txn_end();
    exp_w(5'd6, 8'h77);
    txn_begin();
    tx_byte(8'h86, 8'h00);
    tx_byte(8'h77, 8'h00);
    txn_end();

    // reset in the middle of a write data byte
    exp_w(5'd8, 8'h44);
    txn_begin();
    tx_byte(8'hC8, 8'h00);
    tx_byte(8'h44, 8'h00);
    xfer(8'h5A, 3);
    #2 reset = 1'b1;
    #1 chk_reset_outs("async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    xfer(8'hFF, 5);
    tx_byte(8'h99, 8'h00);
    txn_end();
    chk("post_reset_quiet", exp_q.size(), 32'd0);
    exp_w(5'd9, 8'hBE);
    txn_begin();
    tx_byte(8'h89, 8'h00);
    tx_byte(8'hBE, 8'h00);
    txn_end();

    // random bursts at max SCK rate
    for (int b = 0; b < 20; b++) begin
      wr  = 1'($urandom_range(0, 1));
      inc = 1'($urandom_range(0, 1));
      b5  = 1'($urandom_range(0, 1));
      a   = 5'($urandom_range(0, 31));
      n   = $urandom_range(1, 16);
      txn_begin();
      if (wr) begin
        tx_byte({wr, inc, b5, a}, 8'h00);
        for (int k = 0; k < n; k++) begin
          d = 8'($urandom);
          exp_w(a, d);
          tx_byte(d, 8'h00);
          a = a + {4'd0, inc};
        end
      end else begin
        dv.delete();
        for (int k = 0; k <= n; k++) begin
          d = 8'($urandom);
          dv.push_back(d);
          exp_r(a, d);
          a = a + {4'd0, inc};
        end
        tx_byte({wr, inc, b5, a - 5'(n + 1) * {4'd0, inc}}, 8'h00);
        for (int k = 0; k < n; k++) begin
          tx_byte(8'($urandom), dv[k]);
        end
      end
      txn_end();
    end

    repeat (20) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("rdq_drained", rdq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
